// File: rtl/zipmmu_pkg.sv
// Shared definitions for the zipmmu table loader: sequencer states and
// MMU control-port address field positions.
package zipmmu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_INV,
        ST_CTX
    } tbl_state_t;

    // Control address layout: {table_sel, idx, vp}; table_sel is the MSB.
    localparam int unsigned MMU_VP_BIT   = 0;
    localparam int unsigned MMU_IDX_LSB  = 1;
    localparam int unsigned MMU_CTX_ADDR = 0;

endpackage

// File: rtl/zipmmu_ctlwr.sv
// Single-write handshake on the MMU control port. While i_req is high the
// strobe is raised until the slave accepts it (!i_stall), then the block
// waits for i_ack. An ack in the acceptance cycle is legal. The ack clears
// the accepted flag, so a request held high issues back-to-back writes.
module zipmmu_ctlwr (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_req,
    input  logic i_stall,
    input  logic i_ack,
    output logic o_stb,
    output logic o_ack
);

    logic acc_q, acc_d;

    // Strobe until accepted, then hold off until the acknowledge arrives.
    always_comb begin
        o_stb = i_req & ~acc_q;
        o_ack = i_req & i_ack;
        acc_d = acc_q;
        if (!i_req || i_ack) begin
            acc_d = 1'b0;
        end else if (o_stb && !i_stall) begin
            acc_d = 1'b1;
        end
    end

    // Accepted-strobe flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/zipmmu_tblload.sv
// Bulk TLB loader: reads {vword, pword} pairs from memory over Wishbone and
// writes them into the zipmmu control port, then writes the context word.
// Optional: ZIPMMU_TBLLOAD_INVAL_EN zeroes the virtual words of the unused
// entries N..2^LGTBL-1 before the context write.
module zipmmu_tblload
    import zipmmu_pkg::*;
#(
    parameter int AW    = 30,
    parameter int LGTBL = 6,
    parameter int CTXW  = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [AW-1:0]       i_base,
    input  logic [LGTBL:0]      i_count,
    input  logic [CTXW-1:0]     i_context,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    output logic [AW-1:0]       o_wb_addr,
    input  logic                i_wb_stall,
    input  logic                i_wb_ack,
    input  logic                i_wb_err,
    input  logic [31:0]         i_wb_data,
    output logic                o_mmu_stb,
    output logic                o_mmu_we,
    output logic [LGTBL+1:0]    o_mmu_addr,
    output logic [31:0]         o_mmu_data,
    input  logic                i_mmu_stall,
    input  logic                i_mmu_ack
);

    localparam int WW = LGTBL + 1;
    localparam logic [WW-1:0] N_MAX = {1'b1, {LGTBL{1'b0}}};

    tbl_state_t        state_q, state_d;
    logic [AW-1:0]     base_q, base_d;
    logic [WW-1:0]     n_q, n_d;
    logic [WW-1:0]     w_q, w_d;
    logic [CTXW-1:0]   ctx_q, ctx_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rd_acc_q, rd_acc_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              mmu_req, mmu_ack;
    logic [WW-1:0]     cnt_sat;
    logic [LGTBL-1:0]  idx;
    logic              last_word;

    zipmmu_ctlwr u_ctlwr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_req   (mmu_req),
        .i_stall (i_mmu_stall),
        .i_ack   (i_mmu_ack),
        .o_stb   (o_mmu_stb),
        .o_ack   (mmu_ack)
    );

    // Output decode from the current state; addresses/data are zero when idle.
    always_comb begin
        idx        = w_q[LGTBL:1];
        mmu_req    = (state_q == ST_WR) || (state_q == ST_INV) || (state_q == ST_CTX);
        o_busy     = (state_q != ST_IDLE);
        o_done     = done_q;
        o_err      = err_q;
        o_wb_cyc   = (state_q == ST_RD) & ~i_wb_err;
        o_wb_stb   = (state_q == ST_RD) & ~rd_acc_q & ~i_wb_err;
        o_wb_addr  = (state_q == ST_RD) ? base_q + AW'(w_q) : '0;
        o_mmu_we   = o_mmu_stb;
        o_mmu_addr = '0;
        o_mmu_data = '0;
        case (state_q)
            ST_WR: begin
                o_mmu_addr[LGTBL+1]             = 1'b1;
                o_mmu_addr[LGTBL:MMU_IDX_LSB]   = idx;
                o_mmu_addr[MMU_VP_BIT]          = w_q[0];
                o_mmu_data                      = rdata_q;
            end
            ST_INV: begin
                o_mmu_addr[LGTBL+1]             = 1'b1;
                o_mmu_addr[LGTBL:MMU_IDX_LSB]   = idx;
            end
            ST_CTX: begin
                o_mmu_addr = (LGTBL+2)'(MMU_CTX_ADDR);
                o_mmu_data = 32'(ctx_q);
            end
            default: ;
        endcase
    end

    // Sequencer next-state: read a word, write it, repeat, then the context.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        n_d      = n_q;
        w_d      = w_q;
        ctx_d    = ctx_q;
        rdata_d  = rdata_q;
        rd_acc_d = rd_acc_q;
        err_d    = err_q;
        done_d   = 1'b0;
        cnt_sat   = (i_count > N_MAX) ? N_MAX : i_count;
        last_word = ({1'b0, w_q} == ({n_q, 1'b0} - (WW+1)'(1)));
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    base_d   = i_base;
                    n_d      = cnt_sat;
                    ctx_d    = i_context;
                    err_d    = 1'b0;
                    w_d      = '0;
                    rd_acc_d = 1'b0;
                    state_d  = (cnt_sat == '0) ? ST_CTX : ST_RD;
                end
            end
            ST_RD: begin
                if (i_wb_err) begin
                    err_d    = 1'b1;
                    rd_acc_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (i_wb_ack) begin
                    rdata_d  = i_wb_data;
                    rd_acc_d = 1'b0;
                    state_d  = ST_WR;
                end else if (o_wb_stb && !i_wb_stall) begin
                    rd_acc_d = 1'b1;
                end
            end
            ST_WR: begin
                if (mmu_ack) begin
                    if (last_word) begin
`ifdef ZIPMMU_TBLLOAD_INVAL_EN
                        // w+1 = 2N lands on the virtual word of entry N.
                        if (n_q == N_MAX) begin
                            state_d = ST_CTX;
                        end else begin
                            w_d     = w_q + WW'(1);
                            state_d = ST_INV;
                        end
`else
                        state_d = ST_CTX;
`endif
                    end else begin
                        w_d     = w_q + WW'(1);
                        state_d = ST_RD;
                    end
                end
            end
            ST_INV: begin
                if (mmu_ack) begin
                    if (&idx) begin
                        state_d = ST_CTX;
                    end else begin
                        w_d = w_q + WW'(2);
                    end
                end
            end
            ST_CTX: begin
                if (mmu_ack) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            n_q      <= '0;
            w_q      <= '0;
            ctx_q    <= '0;
            rdata_q  <= '0;
            rd_acc_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            n_q      <= n_d;
            w_q      <= w_d;
            ctx_q    <= ctx_d;
            rdata_q  <= rdata_d;
            rd_acc_q <= rd_acc_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_zipmmu_tblload.sv
// Directed bench for zipmmu_tblload with behavioural Wishbone and MMU slaves.
module tb_zipmmu_tblload;

    localparam int AW    = 30;
    localparam int LGTBL = 6;
    localparam int CTXW  = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [AW-1:0]       base = '0;
    logic [LGTBL:0]      count = '0;
    logic [CTXW-1:0]     ctx = '0;
    logic                busy, done, err;
    logic                wb_cyc, wb_stb;
    logic [AW-1:0]       wb_addr;
    logic                wb_stall = 1'b0, wb_ack = 1'b0, wb_err = 1'b0;
    logic [31:0]         wb_data = '0;
    logic                mmu_stb, mmu_we;
    logic [LGTBL+1:0]    mmu_addr;
    logic [31:0]         mmu_data;
    logic                mmu_stall = 1'b0, mmu_ack = 1'b0;

    always #5 clk = ~clk;

    zipmmu_tblload #(.AW(AW), .LGTBL(LGTBL), .CTXW(CTXW)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_base(base),
        .i_count(count), .i_context(ctx), .o_busy(busy), .o_done(done),
        .o_err(err), .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_addr(wb_addr),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
        .i_wb_data(wb_data), .o_mmu_stb(mmu_stb), .o_mmu_we(mmu_we),
        .o_mmu_addr(mmu_addr), .o_mmu_data(mmu_data),
        .i_mmu_stall(mmu_stall), .i_mmu_ack(mmu_ack)
    );

    int errors = 0;
    int checks = 0;

    bit  rand_mode = 1'b0;
    int  err_at = 0;
    int  rd_n = 0;
    int  done_cnt = 0, overlap_cnt = 0, we_bad = 0, err_cyc_seen = 0;
    logic err_at_start;
    logic [AW-1:0] rd_log[$];
    logic [7:0]    wa_log[$];
    logic [31:0]   wd_log[$];

    function automatic logic [31:0] mem(input logic [AW-1:0] a);
        return 32'hC300_0000 ^ {2'b00, a};
    endfunction

    // Wishbone memory slave: optional stalls and ack delay, optional error.
    bit wb_pend = 1'b0;
    int wb_wait = 0;
    logic [AW-1:0] wb_a;
    always @(negedge clk) begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
        if (wb_cyc) begin
            if (wb_stb && !wb_pend) begin
                wb_stall = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
                if (!wb_stall) begin
                    wb_pend = 1'b1;
                    wb_a = wb_addr;
                    rd_log.push_back(wb_addr);
                    rd_n++;
                    wb_wait = rand_mode ? int'($urandom_range(0, 2)) : 0;
                end
            end
            if (wb_pend) begin
                if (wb_wait == 0) begin
                    wb_pend = 1'b0;
                    if (rd_n == err_at) wb_err = 1'b1;
                    else begin wb_ack = 1'b1; wb_data = mem(wb_a); end
                end else begin
                    wb_wait--;
                end
            end
        end else begin
            wb_pend = 1'b0;
        end
    end

    // Bus must be released in the same cycle as the error response.
    always @(negedge clk) begin
        #1;
        if (wb_err && (wb_cyc || wb_stb)) err_cyc_seen++;
    end

    // MMU control slave plus protocol monitors.
    bit mm_pend = 1'b0;
    int mm_wait = 0;
    always @(negedge clk) begin
        mmu_ack = 1'b0; mmu_stall = 1'b0;
        if (wb_stb && mmu_stb) overlap_cnt++;
        if (done) done_cnt++;
        if (mmu_stb && !mm_pend) begin
            mmu_stall = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (!mmu_stall) begin
                mm_pend = 1'b1;
                wa_log.push_back(mmu_addr);
                wd_log.push_back(mmu_data);
                if (mmu_we !== 1'b1) we_bad++;
                mm_wait = rand_mode ? int'($urandom_range(0, 2)) : 0;
            end
        end
        if (mm_pend) begin
            if (mm_wait == 0) begin mm_pend = 1'b0; mmu_ack = 1'b1; end
            else mm_wait--;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete(); wa_log.delete(); wd_log.delete();
        done_cnt = 0; overlap_cnt = 0; we_bad = 0; err_cyc_seen = 0; rd_n = 0;
    endtask

    // One start pulse, then wait (bounded) for o_busy to fall.
    task automatic run(input logic [AW-1:0] b, input logic [LGTBL:0] c,
                       input logic [CTXW-1:0] x, output int lat);
        clear_logs();
        @(negedge clk);
        base = b; count = c; ctx = x; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        err_at_start = err;
        lat = 1;
        while (busy && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        #2;
        chk("run_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int bad;
        int k;
        logic [AW-1:0] a;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_wb", {30'd0, wb_cyc, wb_stb}, 0);
        chk("rst_mmu_stb", {31'd0, mmu_stb}, 0);
        chk("rst_addrs", {2'b00, wb_addr} | 32'(mmu_addr) | mmu_data, 0);
        rst = 1'b0;

        // Basic two-entry load, zero-stall same-cycle-ack slaves
        run(30'h100, 7'd2, 16'h0005, lat);
        chk("t1_lat", lat, 10);
        chk("t1_nrd", rd_log.size(), 4);
        chk("t1_nwr", wa_log.size(), 5);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rdaddr", 32'(rd_log[i]), 32'h100 + i);
            chk("t1_wraddr", 32'(wa_log[i]), 32'h80 + i);
            chk("t1_wrdata", wd_log[i], mem(30'h100 + 30'(i)));
        end
        chk("t1_ctxaddr", 32'(wa_log[4]), 0);
        chk("t1_ctxdata", wd_log[4], 32'h5);
        chk("t1_done", done_cnt, 1);
        chk("t1_err", {31'd0, err}, 0);

        // Zero entries: only the context write
        run(30'h100, 7'd0, 16'hBEEF, lat);
        chk("t2_lat", lat, 2);
        chk("t2_nrd", rd_log.size(), 0);
        chk("t2_nwr", wa_log.size(), 1);
        chk("t2_ctxaddr", 32'(wa_log[0]), 0);
        chk("t2_ctxdata", wd_log[0], 32'h0000_BEEF);
        chk("t2_done", done_cnt, 1);

        // Full table with random stalls/delays; count saturates, address wraps
        rand_mode = 1'b1;
        run(30'h3FFF_FFF0, 7'd100, 16'h1234, lat);
        rand_mode = 1'b0;
        chk("t3_nrd", rd_log.size(), 128);
        chk("t3_nwr", wa_log.size(), 129);
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            a = 30'h3FFF_FFF0 + 30'(i);
            if (rd_log[i] !== a || wa_log[i] !== 8'(8'h80 + i) || wd_log[i] !== mem(a)) bad++;
        end
        chk("t3_ordered_writes_bad", bad, 0);
        chk("t3_ctxaddr", 32'(wa_log[128]), 0);
        chk("t3_ctxdata", wd_log[128], 32'h1234);
        chk("t3_overlap", overlap_cnt, 0);
        chk("t3_we", we_bad, 0);
        chk("t3_done", done_cnt, 1);

        // Bus error on the third read
        err_at = 3;
        run(30'h200, 7'd4, 16'h0009, lat);
        err_at = 0;
        chk("t4_nrd", rd_log.size(), 3);
        chk("t4_cyc_drop", err_cyc_seen, 0);
        chk("t4_err", {31'd0, err}, 1);
        chk("t4_nwr", wa_log.size(), 2);
        chk("t4_done", done_cnt, 0);
        run(30'h300, 7'd1, 16'h0003, lat);
        chk("t4_err_clr", {31'd0, err_at_start}, 0);
        chk("t4b_nwr", wa_log.size(), 3);
        chk("t4b_done", done_cnt, 1);
        chk("t4b_err", {31'd0, err}, 0);

        // Reset during the second table write
        clear_logs();
        @(negedge clk);
        base = 30'h400; count = 7'd4; ctx = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(mmu_stb && mmu_addr == 8'h81) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reach_wr2", {31'd0, k < 200}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_strobes", {29'd0, wb_cyc, wb_stb, mmu_stb}, 0);
        rst = 1'b0;
        #2;
        chk("t5_done", done_cnt, 0);
        run(30'h500, 7'd1, 16'h0007, lat);
        chk("t5b_nwr", wa_log.size(), 3);
        chk("t5b_wr1", {24'd0, wa_log[1]}, 32'h81);
        chk("t5b_wd1", wd_log[1], mem(30'h501));
        chk("t5b_ctx", {24'd0, wa_log[2]}, 0);
        chk("t5b_done", done_cnt, 1);

        // 62 entries: trailing entries invalidated only with the option built in
        run(30'h0, 7'd62, 16'h0002, lat);
`ifdef ZIPMMU_TBLLOAD_INVAL_EN
        chk("t6_nwr", wa_log.size(), 127);
        chk("t6_inv0_addr", {24'd0, wa_log[124]}, 32'hFC);
        chk("t6_inv0_data", wd_log[124], 0);
        chk("t6_inv1_addr", {24'd0, wa_log[125]}, 32'hFE);
        chk("t6_inv1_data", wd_log[125], 0);
        chk("t6_ctx", {24'd0, wa_log[126]}, 0);
`else
        chk("t6_nwr", wa_log.size(), 125);
        chk("t6_last", {24'd0, wa_log[123]}, 32'hFB);
        chk("t6_ctx", {24'd0, wa_log[124]}, 0);
`endif
        chk("t6_done", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
